// File: rtl/plot_sink.sv
// rtl/plot_sink.sv - clipping pixel sink with FIFO buffering toward a framebuffer write port
//
// Purpose:
//   Samples a drawer's pixel stream every clock, discards off-screen pixels,
//   converts (x,y) to a linear framebuffer address, buffers accepted pixels and
//   drains them through a registered valid/ready write port. Tracks the
//   drawer's done level and reports when every accepted pixel has been written.
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   vga_x/vga_y/vga_colour   pixel from drawer
//   vga_plot                 pixel valid, no backpressure toward the drawer
//   src_done                 drawer finished (level)
//   fb_addr/fb_colour/fb_we  framebuffer write request (registered)
//   fb_ready                 framebuffer accepts when fb_we && fb_ready
//   full                     FIFO holds DEPTH entries
//   busy                     work buffered, pending or drawer active
//   flush_done               all accepted pixels written after src_done
//   clip_count/drop_count    saturating event counters

module plot_sink #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        vga_x,
    input  logic [6:0]        vga_y,
    input  logic [2:0]        vga_colour,
    input  logic              vga_plot,
    input  logic              src_done,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [2:0]        fb_colour,
    output logic              fb_we,
    input  logic              fb_ready,
    output logic              full,
    output logic              busy,
    output logic              flush_done,
    output logic [15:0]       clip_count,
    output logic [15:0]       drop_count
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = ADDR_W + 3;

    localparam logic [8:0]       X_LIM    = 9'(WIDTH);
    localparam logic [7:0]       Y_LIM    = 8'(HEIGHT);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;

    logic [ADDR_W-1:0]  fb_addr_q;
    logic [2:0]         fb_colour_q;
    logic               fb_we_q;

    logic [15:0]        clip_q, drop_q;

    logic               in_range;
    logic [ADDR_W-1:0]  addr_calc;
    logic               hs;
    logic               pop;
    logic               push;
    logic               clip_evt;
    logic               drop_evt;
    logic [ENTRY_W-1:0] head;

    assign in_range  = ({1'b0, vga_x} < X_LIM) && ({1'b0, vga_y} < Y_LIM);

    // y*160 + x as two shifts and adds
    assign addr_calc = ADDR_W'({vga_y, 7'b0}) + ADDR_W'({vga_y, 5'b0}) + ADDR_W'(vga_x);

    assign hs   = fb_we_q && fb_ready;
    // Refill the output register whenever it is empty or emptying this edge
    assign pop  = (count_q != '0) && (!fb_we_q || hs);
    // A full FIFO still accepts if its head leaves on the same edge
    assign push = vga_plot && in_range && ((count_q != CNT_FULL) || pop);

    assign clip_evt = vga_plot && !in_range;
    assign drop_evt = vga_plot && in_range && !push;

    assign head = mem_q[rd_ptr_q];

    // Storage array is not reset; only the pointers and count define content
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wr_ptr_q] <= {addr_calc, vga_colour};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fb_addr_q   <= '0;
            fb_colour_q <= '0;
            fb_we_q     <= 1'b0;
        end else if (pop) begin
            fb_addr_q   <= head[ENTRY_W-1:3];
            fb_colour_q <= head[2:0];
            fb_we_q     <= 1'b1;
        end else if (hs) begin
            fb_we_q     <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clip_q <= '0;
            drop_q <= '0;
        end else begin
            if (clip_evt && (clip_q != 16'hFFFF)) begin
                clip_q <= clip_q + 16'd1;
            end
            if (drop_evt && (drop_q != 16'hFFFF)) begin
                drop_q <= drop_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (src_done) begin
                    state_d = S_DRAIN;
                end else if (vga_plot) begin
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (src_done) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Done only once nothing is buffered, presented or arriving
                if ((count_q == '0) && !fb_we_q && !push) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (push) begin
                    state_d = S_DRAIN;
                end else if (!src_done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign fb_addr    = fb_addr_q;
    assign fb_colour  = fb_colour_q;
    assign fb_we      = fb_we_q;
    assign full       = (count_q == CNT_FULL);
    assign busy       = (count_q != '0) || fb_we_q ||
                        (state_q == S_ACTIVE) || (state_q == S_DRAIN);
    assign flush_done = (state_q == S_DONE);
    assign clip_count = clip_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_plot_sink.sv
// tb/tb_plot_sink.sv - scoreboard bench for plot_sink with randomized and directed stimulus

module tb_plot_sink;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  vga_x = '0;
    logic [6:0]  vga_y = '0;
    logic [2:0]  vga_colour = '0;
    logic        vga_plot = 1'b0;
    logic        src_done = 1'b0;
    logic [14:0] fb_addr;
    logic [2:0]  fb_colour;
    logic        fb_we;
    logic        fb_ready = 1'b0;
    logic        full;
    logic        busy;
    logic        flush_done;
    logic [15:0] clip_count;
    logic [15:0] drop_count;

    always #5 clk = ~clk;

    plot_sink dut (
        .clk        (clk),
        .rst        (rst),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .src_done   (src_done),
        .fb_addr    (fb_addr),
        .fb_colour  (fb_colour),
        .fb_we      (fb_we),
        .fb_ready   (fb_ready),
        .full       (full),
        .busy       (busy),
        .flush_done (flush_done),
        .clip_count (clip_count),
        .drop_count (drop_count)
    );

    // Reference model: pixels accepted but not yet written, in sample order.
    // The sink holds at most 17 pixels (16 queued plus one presented); a new
    // pixel is lost only when all 17 slots are taken and none leaves that edge.
    logic [17:0] sbq[$];
    int          occ = 0;
    logic [15:0] clip_exp = '0;
    logic [15:0] drop_exp = '0;
    bit          started = 0;
    int          hs_total = 0;
    int          total = 0;
    int          bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every write handshake is checked against the oldest expected pixel
    initial begin
        logic [17:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (started && !rst && fb_we && fb_ready) begin
                hs_total++;
                if (sbq.size() == 0) begin
                    check("unexpected_write", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    check("fb_addr", 32'(fb_addr), 32'(e[17:3]));
                    check("fb_colour", 32'(fb_colour), 32'(e[2:0]));
                end
            end
        end
    end

    // One clock of stimulus; the model predicts the effect of the coming edge
    task automatic step(input logic r, input logic p, input logic [7:0] x, input logic [6:0] y,
                        input logic [2:0] c, input logic rdy, input logic d, output bit hs);
        int xi;
        int yi;
        @(negedge clk);
        rst = r; vga_plot = p; vga_x = x; vga_y = y; vga_colour = c;
        fb_ready = rdy; src_done = d;
        #1;
        if (started) begin
            check("full", 32'(full), 32'(occ == 17));
            check("clip_count", 32'(clip_count), 32'(clip_exp));
            check("drop_count", 32'(drop_count), 32'(drop_exp));
        end
        hs = started && !r && fb_we && fb_ready;
        if (r) begin
            sbq.delete();
            occ = 0;
            clip_exp = '0;
            drop_exp = '0;
            started = 1;
        end else begin
            xi = int'(x);
            yi = int'(y);
            if (p) begin
                if (xi >= 160 || yi >= 120) begin
                    if (clip_exp != 16'hFFFF) clip_exp++;
                end else if (occ < 17 || hs) begin
                    sbq.push_back({15'(yi * 160 + xi), c});
                    occ++;
                end else begin
                    if (drop_exp != 16'hFFFF) drop_exp++;
                end
            end
            if (hs) occ--;
        end
    endtask

    task automatic idle(input logic rdy, input logic d);
        bit h;
        step(1'b0, 1'b0, 8'd0, 7'd0, 3'd0, rdy, d, h);
    endtask

    task automatic plot(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c,
                        input logic rdy, input logic d);
        bit h;
        step(1'b0, 1'b1, x, y, c, rdy, d, h);
    endtask

    task automatic do_reset();
        bit h;
        step(1'b1, 1'b0, 8'd0, 7'd0, 3'd0, 1'b0, 1'b0, h);
    endtask

    initial begin
        bit h;
        int base;
        int cnt;
        int n5;

        // 1. reset held two cycles with plot asserted
        step(1'b1, 1'b1, 8'd80, 7'd60, 3'd1, 1'b1, 1'b0, h);
        step(1'b1, 1'b1, 8'd80, 7'd60, 3'd1, 1'b1, 1'b0, h);
        idle(1'b0, 1'b0);
        check("rst_fb_we", 32'(fb_we), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_flush", 32'(flush_done), 32'd0);
        check("rst_clip", 32'(clip_count), 32'd0);
        check("rst_drop", 32'(drop_count), 32'd0);

        // 2. single pixel latency and address
        do_reset();
        plot(8'd80, 7'd60, 3'b010, 1'b1, 1'b0);
        idle(1'b1, 1'b0);
        check("lat_we_n", 32'(fb_we), 32'd0);
        idle(1'b1, 1'b0);
        check("lat_we_n1", 32'(fb_we), 32'd1);
        check("lat_addr", 32'(fb_addr), 32'd9680);
        check("lat_colour", 32'(fb_colour), 32'd2);
        check("lat_busy", 32'(busy), 32'd1);
        idle(1'b1, 1'b0);
        check("lat_we_off", 32'(fb_we), 32'd0);

        // 3. clipping boundaries
        do_reset();
        base = hs_total;
        plot(8'd160, 7'd0, 3'd5, 1'b1, 1'b0);
        plot(8'd0, 7'd120, 3'd6, 1'b1, 1'b0);
        plot(8'd159, 7'd119, 3'd7, 1'b1, 1'b0);
        repeat (4) idle(1'b1, 1'b0);
        check("clip_two", 32'(clip_count), 32'd2);
        check("clip_writes", 32'(hs_total - base), 32'd1);

        // 4. overflow with stalled framebuffer, then full-rate drain
        do_reset();
        for (int i = 0; i < 20; i++) begin
            plot(8'(i * 7), 7'(i * 5), 3'(i), 1'b0, 1'b0);
        end
        idle(1'b0, 1'b0);
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_drop", 32'(drop_count), 32'd3);
        check("ovf_busy", 32'(busy), 32'd1);
        base = hs_total;
        for (int i = 0; i < 17; i++) begin
            idle(1'b1, 1'b0);
            check("drain_we", 32'(fb_we), 32'd1);
        end
        idle(1'b1, 1'b0);
        check("drain_we_end", 32'(fb_we), 32'd0);
        check("drain_writes", 32'(hs_total - base), 32'd17);

        // 5. flush_done timing with toggling ready
        do_reset();
        for (int i = 0; i < 5; i++) begin
            plot(8'(10 + i), 7'(20 + i), 3'(i), 1'b0, 1'b0);
        end
        cnt = 0;
        n5 = -1;
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 1'b0, 8'd0, 7'd0, 3'd0, 1'(i % 2), 1'b1, h);
            check("flush_timing", 32'(flush_done), 32'(n5 >= 0 && i >= n5 + 2));
            if (h) cnt++;
            if (cnt == 5 && n5 < 0) n5 = i;
        end
        check("flush_hs", 32'(cnt), 32'd5);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);
        check("flush_clear", 32'(flush_done), 32'd0);

        // 6. reset in the middle of a drain
        do_reset();
        plot(8'd200, 7'd5, 3'd1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            plot(8'(30 + i), 7'(40), 3'(i), 1'b0, 1'b0);
        end
        idle(1'b0, 1'b1);
        idle(1'b0, 1'b1);
        step(1'b1, 1'b0, 8'd0, 7'd0, 3'd0, 1'b1, 1'b1, h);
        idle(1'b1, 1'b0);
        check("mid_we", 32'(fb_we), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_flush", 32'(flush_done), 32'd0);
        check("mid_clip", 32'(clip_count), 32'd0);
        check("mid_full", 32'(full), 32'd0);
        base = hs_total;
        repeat (6) idle(1'b1, 1'b0);
        check("mid_no_writes", 32'(hs_total - base), 32'd0);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            step(1'b0, 1'($urandom_range(0, 9) < 8), 8'($urandom_range(0, 175)),
                 7'($urandom_range(0, 127)), 3'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 19) == 0), h);
        end
        for (int i = 0; i < 100 && sbq.size() != 0; i++) begin
            idle(1'b1, 1'b0);
        end
        idle(1'b1, 1'b0);
        check("random_drained", 32'(sbq.size()), 32'd0);
        check("random_we_idle", 32'(fb_we), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
